uart_rx_fifo_param: RTL
=======================

Name: uart_rx_fifo_param

Overview:
Parametrised UART receiver, successor to the fixed 8N1 receiver.
- Configurable data width, per-frame parity and stop-bit count.
- Per-word parity/framing error tags, break detection, receive FIFO with overrun flag.
- Sits between the MIDI/serial pin and the host register interface; the host drains words through a show-ahead read port.

Parameters:
DATA_BITS, 8, data bits per frame, legal 5..9.
FIFO_DEPTH, 16, receive FIFO entries, power of two, legal 2..256.
CNT_W, $clog2(FIFO_DEPTH+1), width of fifo_count (derived, not overridden).

Ports:
clk  in  1  clock
rst  in  1  reset: synchronous, active-high
RX  in  1  asynchronous serial line, idle high
clk_div  in  16  clocks per bit; legal range >= 4
parity_en  in  1  parity bit present after data
parity_odd  in  1  1 = odd parity, 0 = even
two_stop  in  1  1 = two stop bits checked
rd_en  in  1  pop FIFO head
rd_valid  out  1  FIFO not empty
rd_data  out  DATA_BITS  FIFO head data (show-ahead)
rd_perr  out  1  FIFO head parity-error tag
rd_ferr  out  1  FIFO head framing-error tag
fifo_count  out  CNT_W  current occupancy
overrun  out  1  sticky: word dropped because FIFO was full
break_det  out  1  one-cycle pulse on break
clr_err  in  1  clears overrun

Behaviour:
- Reset values: all outputs 0, FIFO empty, state IDLE.
  - Both synchroniser flops preset to 1.
  - Reset mid-frame aborts the frame and discards the partial word.
- RX passes through a 2-flop synchroniser to give rx_s. All sampling uses rx_s.
- Baud counter:
  - Loaded with L, decrements each cycle; a sample event occurs on the cycle it equals 0.
  - Interval between load and sample is therefore L+1 cycles.
  - Start load: clk_div>>1. Every other reload: clk_div-1.
- Config inputs are latched at start detection and held constant for the frame.
- FSM states: IDLE, START, DATA, PARITY, STOP, WAIT_IDLE.
  - IDLE: rx_s==0 -> load half-bit, go START.
  - START: at sample, rx_s==1 -> false start, go IDLE, nothing pushed; else go DATA.
  - DATA: DATA_BITS samples, LSB first, into the shift register. Then go PARITY if parity_en, else STOP.
  - PARITY: one sample; perr = XOR(data, parity bit) != parity_odd.
  - STOP: one sample, or two if two_stop. Any stop sample 0 -> ferr=1.
- End of frame, on the last stop sample:
  - Break: data all 0, parity bit (if present) 0, first stop 0. Then pulse break_det, no push, go WAIT_IDLE.
  - Else if ferr: push {ferr, perr, data}, go WAIT_IDLE.
  - Else: push, go IDLE.
- WAIT_IDLE: stay until rx_s==1, then go IDLE. This prevents a retrigger on a held-low line.
- FIFO:
  - Push result is visible on rd_valid/rd_data the cycle after the push.
  - rd_en with FIFO empty is ignored.
  - Full without pop: push dropped, overrun set.
  - Full with push and pop in the same cycle: both occur, count unchanged, no overrun.
  - Pointers wrap modulo FIFO_DEPTH.
- Overrun: cleared by clr_err. Set and clear in the same cycle: set wins.

Optional Feature:
UART_RX_MAJORITY_EN
- Defined: every sample (start, data, parity, stop) is the 2-of-3 majority of rx_s captured at counter values 2, 1 and 0.
- Undefined: single rx_s capture at counter 0.
- Bit timing is identical in both builds.

Decomposition:
- Package uart_pkg holds:
  - rx_state_t enum.
  - Struct rx_entry_t {ferr, perr, data}, parametrised via a DATA_BITS localparam in the instantiating scope, or passed as a packed vector width.
  - Constants MIN_CLK_DIV=4 and the PARITY_EVEN/PARITY_ODD encodings.
- Sub-module uart_rx_sync_fifo: generic show-ahead synchronous FIFO with WIDTH and DEPTH parameters, push/pop/full/empty/count. The FSM and baud logic stay in the top.

Test Plan:
1. clk_div=16, 8N1, send 0xA5 -> rd_valid rises 155–157 cycles after the RX falling edge; rd_data=0xA5, rd_perr=0, rd_ferr=0; rd_en pop -> rd_valid=0, fifo_count=0.
2. parity_en=1, parity_odd=0, send 0x3C with parity bit 1 (wrong) -> rd_data=0x3C, rd_perr=1; then 0x3C with parity 0 -> rd_perr=0.
3. clk_div=16, RX low for 3 cycles then high -> false start, fifo_count stays 0, FSM back in IDLE within 12 cycles.
4. RX held low for 20 bit times, then high -> exactly one break_det pulse, no push, no new frame starts until RX returns high.
5. FIFO_DEPTH=16, send 17 bytes 0x00..0x10 without reads -> fifo_count=16, overrun=1, reads return 0x00..0x0F; clr_err -> overrun=0. Also: push and pop in the same cycle at full -> count stays 16, overrun stays 0.
6. DATA_BITS=7, two_stop=1, second stop bit driven 0 -> word pushed with rd_ferr=1, FSM waits in WAIT_IDLE. Separately, assert rst mid-DATA -> all outputs 0 and the next clean frame is received correctly.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and constants for the parametrised UART receiver.
// Build option: UART_RX_MAJORITY_EN selects 2-of-3 majority bit sampling.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
        PARITY    = 3'd3,
        STOP      = 3'd4,
        WAIT_IDLE = 3'd5
    } rx_state_t;

    localparam int MAX_DATA_BITS = 9;
    localparam int MIN_CLK_DIV   = 4;

    localparam logic PARITY_EVEN = 1'b0;
    localparam logic PARITY_ODD  = 1'b1;

    // Widest entry; narrower builds carry {ferr, perr, data} as a packed vector of DATA_BITS+2.
    typedef struct packed {
        logic                     ferr;
        logic                     perr;
        logic [MAX_DATA_BITS-1:0] data;
    } rx_entry_t;

endpackage

// File: rtl/uart_rx_sync_fifo.sv
// Generic show-ahead synchronous FIFO: head word is always visible on dout.
// A push into a full FIFO is accepted only when a pop happens in the same cycle.
module uart_rx_sync_fifo
    import uart_pkg::*;
#(
    parameter int WIDTH = 10,
    parameter int DEPTH = 16,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push, do_pop;

    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);
    assign count = count_q;
    assign dout  = mem_q[rd_ptr_q];

    always_comb begin
        do_push  = push && (!full || pop);
        do_pop   = pop && !empty;
        wr_ptr_d = wr_ptr_q + AW'(do_push);
        rd_ptr_d = rd_ptr_q + AW'(do_pop);
        count_d  = count_q;
        if (do_push && !do_pop) begin
            count_d = count_q + CW'(1);
        end else if (!do_push && do_pop) begin
            count_d = count_q - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage carries no reset; only occupied slots are ever observed.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

endmodule

// File: rtl/uart_rx_fifo_param.sv
// Parametrised UART receiver: sync, baud timing, frame FSM, break detect, receive FIFO.
// Build option: UART_RX_MAJORITY_EN votes each bit from captures at counter values 2, 1, 0.
module uart_rx_fifo_param
    import uart_pkg::*;
#(
    parameter int DATA_BITS  = 8,
    parameter int FIFO_DEPTH = 16,
    parameter int CNT_W      = $clog2(FIFO_DEPTH + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 RX,
    input  logic [15:0]          clk_div,
    input  logic                 parity_en,
    input  logic                 parity_odd,
    input  logic                 two_stop,
    input  logic                 rd_en,
    output logic                 rd_valid,
    output logic [DATA_BITS-1:0] rd_data,
    output logic                 rd_perr,
    output logic                 rd_ferr,
    output logic [CNT_W-1:0]     fifo_count,
    output logic                 overrun,
    output logic                 break_det,
    input  logic                 clr_err,
    output rx_state_t            dbg_state
);

    localparam int EW = DATA_BITS + 2;

    rx_state_t            state_q, state_d;
    logic                 sync1_q, rx_s_q;
    logic [15:0]          cnt_q, cnt_d;
    logic [3:0]           bit_cnt_q, bit_cnt_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 par_bit_q, par_bit_d;
    logic                 perr_q, perr_d;
    logic                 ferr_q, ferr_d;
    logic                 first_low_q, first_low_d;
    logic                 par_en_q, par_en_d;
    logic                 par_odd_q, par_odd_d;
    logic                 two_stop_q, two_stop_d;
    logic                 overrun_q, overrun_d;
    logic                 brk_q, brk_d;

    logic                 sample, bit_s, stop_fe, stop_fl;
    logic                 push_req;
    logic [EW-1:0]        push_data, head;
    logic                 fifo_full, fifo_empty;

`ifdef UART_RX_MAJORITY_EN
    logic m2_q, m2_d, m1_q, m1_d;

    always_comb begin
        m2_d  = (cnt_q == 16'd2) ? rx_s_q : m2_q;
        m1_d  = (cnt_q == 16'd1) ? rx_s_q : m1_q;
        bit_s = (m2_q & m1_q) | (m2_q & rx_s_q) | (m1_q & rx_s_q);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            m2_q <= 1'b1;
            m1_q <= 1'b1;
        end else begin
            m2_q <= m2_d;
            m1_q <= m1_d;
        end
    end
`else
    assign bit_s = rx_s_q;
`endif

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        par_bit_d   = par_bit_q;
        perr_d      = perr_q;
        ferr_d      = ferr_q;
        first_low_d = first_low_q;
        par_en_d    = par_en_q;
        par_odd_d   = par_odd_q;
        two_stop_d  = two_stop_q;
        push_req    = 1'b0;
        push_data   = '0;
        brk_d       = 1'b0;
        stop_fe     = 1'b0;
        stop_fl     = 1'b0;
        sample      = (cnt_q == 16'd0);

        if ((state_q inside {START, DATA, PARITY, STOP}) && !sample) begin
            cnt_d = cnt_q - 16'd1;
        end

        case (state_q)
            IDLE: begin
                if (!rx_s_q) begin
                    state_d     = START;
                    cnt_d       = clk_div >> 1;
                    par_en_d    = parity_en;
                    par_odd_d   = parity_odd;
                    two_stop_d  = two_stop;
                    bit_cnt_d   = '0;
                    par_bit_d   = 1'b0;
                    perr_d      = 1'b0;
                    ferr_d      = 1'b0;
                    first_low_d = 1'b0;
                end
            end
            START: begin
                if (sample) begin
                    if (bit_s) begin
                        state_d = IDLE;
                    end else begin
                        state_d = DATA;
                        cnt_d   = clk_div - 16'd1;
                    end
                end
            end
            DATA: begin
                if (sample) begin
                    shift_d = {bit_s, shift_q[DATA_BITS-1:1]};
                    cnt_d   = clk_div - 16'd1;
                    if (bit_cnt_q == 4'(DATA_BITS - 1)) begin
                        bit_cnt_d = '0;
                        state_d   = par_en_q ? PARITY : STOP;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end
                end
            end
            PARITY: begin
                if (sample) begin
                    par_bit_d = bit_s;
                    perr_d    = ((^shift_q) ^ bit_s) != par_odd_q;
                    cnt_d     = clk_div - 16'd1;
                    state_d   = STOP;
                end
            end
            STOP: begin
                if (sample) begin
                    stop_fe     = ferr_q | ~bit_s;
                    stop_fl     = (bit_cnt_q == 4'd0) ? ~bit_s : first_low_q;
                    ferr_d      = stop_fe;
                    first_low_d = stop_fl;
                    if (two_stop_q && bit_cnt_q == 4'd0) begin
                        bit_cnt_d = 4'd1;
                        cnt_d     = clk_div - 16'd1;
                    end else if (shift_q == '0 && !(par_en_q && par_bit_q) && stop_fl) begin
                        // Line held low through the whole frame: report a break, store nothing.
                        brk_d   = 1'b1;
                        state_d = WAIT_IDLE;
                    end else begin
                        push_req  = 1'b1;
                        push_data = {stop_fe, perr_q, shift_q};
                        state_d   = stop_fe ? WAIT_IDLE : IDLE;
                    end
                end
            end
            WAIT_IDLE: begin
                if (rx_s_q) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        overrun_d = (push_req && fifo_full && !rd_en) || (overrun_q && !clr_err);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            sync1_q     <= 1'b1;
            rx_s_q      <= 1'b1;
            cnt_q       <= '0;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            par_bit_q   <= 1'b0;
            perr_q      <= 1'b0;
            ferr_q      <= 1'b0;
            first_low_q <= 1'b0;
            par_en_q    <= 1'b0;
            par_odd_q   <= 1'b0;
            two_stop_q  <= 1'b0;
            overrun_q   <= 1'b0;
            brk_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            sync1_q     <= RX;
            rx_s_q      <= sync1_q;
            cnt_q       <= cnt_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            par_bit_q   <= par_bit_d;
            perr_q      <= perr_d;
            ferr_q      <= ferr_d;
            first_low_q <= first_low_d;
            par_en_q    <= par_en_d;
            par_odd_q   <= par_odd_d;
            two_stop_q  <= two_stop_d;
            overrun_q   <= overrun_d;
            brk_q       <= brk_d;
        end
    end

    uart_rx_sync_fifo #(
        .WIDTH (EW),
        .DEPTH (FIFO_DEPTH),
        .CW    (CNT_W)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push_req),
        .pop   (rd_en),
        .din   (push_data),
        .dout  (head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // Head fields are masked while empty so the outputs read 0 rather than stale storage.
    assign rd_valid  = !fifo_empty;
    assign rd_data   = rd_valid ? head[DATA_BITS-1:0] : '0;
    assign rd_perr   = rd_valid & head[DATA_BITS];
    assign rd_ferr   = rd_valid & head[DATA_BITS+1];
    assign overrun   = overrun_q;
    assign break_det = brk_q;
    assign dbg_state = state_q;

endmodule
